// File: rtl/des_pkg.sv
// Shared DES constants: permutation and S-box tables, shift schedule, FSM state enum,
// plus the pure bit-shuffling helpers used by the round datapath and the controller.
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int HALF_W   = 32;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // All tables use DES numbering: entry n names input bit n, bit 1 being the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each box is 4 rows x 16 columns flattened; index = {row, col}.
  localparam int SBOX_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] des_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] des_sbox(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      b = x[6'(47 - 6 * i) -: 6];
      y[5'(31 - 4 * i) -: 4] = 4'(SBOX_T[3'(i)][{b[5], b[0], b[4:1]}]);
    end
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    return (x >> n) | (x << (28 - n));
  endfunction

endpackage

// File: rtl/des_round_f.sv
// DES Feistel function f(R,K) = P(S(E(R) ^ K)); purely combinational.
module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);

  logic [47:0] mixed;

  assign mixed = des_expand(r_i) ^ k_i;
  assign f_o   = des_p(des_sbox(mixed));

endmodule

// File: rtl/des_round_controller.sv
// Iterative DES sequencer: one Feistel round per clock over a shared des_round_f.
// Define DES_DECRYPT_EN to add the mode port and the reverse key schedule.
module des_round_controller
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
`ifdef DES_DECRYPT_EN
  input  logic        mode,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshakes: a block is taken on in_valid & in_ready (in_ready only ever high in IDLE);
  // a result leaves on out_valid & out_ready, with out_valid/data_out held until then.

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      l_q, r_q, r_d, f_val;
  logic [27:0]      c_q, d_q, c_d, d_d;
  logic [47:0]      subkey;
  logic [63:0]      dout_q;
  logic             ovalid_q, iready_q, busy_q;
`ifdef DES_DECRYPT_EN
  logic             mode_q;
`endif

  always_comb begin
    c_d    = rotl28(c_q, SHIFT_T[4'(cnt_q)]);
    d_d    = rotl28(d_q, SHIFT_T[4'(cnt_q)]);
    subkey = des_pc2({c_d, d_d});
`ifdef DES_DECRYPT_EN
    // Decrypt walks K16..K1: use the current C/D, then undo that round's rotation.
    if (mode_q) begin
      subkey = des_pc2({c_q, d_q});
      c_d    = rotr28(c_q, SHIFT_T[4'd15 - 4'(cnt_q)]);
      d_d    = rotr28(d_q, SHIFT_T[4'd15 - 4'(cnt_q)]);
    end
`endif
  end

  des_round_f u_round_f (
    .r_i (r_q),
    .k_i (subkey),
    .f_o (f_val)
  );

  assign r_d = l_q ^ f_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      l_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
      iready_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DES_DECRYPT_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && iready_q) begin
            {l_q, r_q} <= des_ip(data_in);
            {c_q, d_q} <= des_pc1(key_in);
            cnt_q      <= '0;
`ifdef DES_DECRYPT_EN
            mode_q     <= mode;
`endif
            iready_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_ROUND;
          end else begin
            iready_q   <= 1'b1;
          end
        end
        ST_ROUND: begin
          l_q   <= r_q;
          r_q   <= r_d;
          c_q   <= c_d;
          d_q   <= d_d;
          cnt_q <= cnt_q + 1'b1;
          // Final round: output is FP(R16,L16), i.e. the last swap is undone.
          if (cnt_q == CNT_W'(NUM_ROUNDS - 1)) begin
            dout_q   <= des_fp({r_d, r_q});
            ovalid_q <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            ovalid_q <= 1'b0;
            busy_q   <= 1'b0;
            iready_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = iready_q;
  assign out_valid = ovalid_q;
  assign data_out  = dout_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_des_round_controller.sv
// Self-checking bench for des_round_controller using published DES test vectors.
module tb_des_round_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data_in = '0;
  logic [63:0] key_in = '0;
`ifdef DES_DECRYPT_EN
  logic        mode = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] data_out;
  logic        busy;
  logic [1:0]  state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  des_round_controller dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_in    (key_in),
`ifdef DES_DECRYPT_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- reference vectors ----------------
  localparam int NV = 6;
  logic [63:0] v_key [NV];
  logic [63:0] v_pt  [NV];
  logic [63:0] v_ct  [NV];

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q [$];
  int          acc_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          scramble = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          prev_ov = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov && acc_q.size() != 0)
        check_eq("latency", 64'(cyc - acc_q.pop_front()), 64'd17);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_out", 64'(out_valid), 64'd0);
        else                   check_eq("data_out", data_out, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  // Garbage on the inputs while the engine is busy must not leak into the result.
  always @(posedge clk) begin
    #1;
    if (scramble && !in_ready && !rst) begin
      data_in = {$urandom, $urandom};
      key_in  = {$urandom, $urandom};
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  int last_acc = 0;

  task automatic send(input logic [63:0] pt, input logic [63:0] key,
                      input logic [63:0] exp, input bit hold);
    int waited = 0;
    @(posedge clk); #1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1;
    data_in  = pt;
    key_in   = key;
    exp_q.push_back(exp);
    acc_q.push_back(cyc);
    last_acc = cyc;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int prev_acc;
    int idx;
    v_key[0] = 64'h133457799BBCDFF1; v_pt[0] = 64'h0123456789ABCDEF; v_ct[0] = 64'h85E813540F0AB405;
    v_key[1] = 64'h0000000000000000; v_pt[1] = 64'h0000000000000000; v_ct[1] = 64'h8CA64DE9C1B123A7;
    v_key[2] = 64'hFFFFFFFFFFFFFFFF; v_pt[2] = 64'hFFFFFFFFFFFFFFFF; v_ct[2] = 64'h7359B2163E4EDC58;
    v_key[3] = 64'h0123456789ABCDEF; v_pt[3] = 64'h4E6F772069732074; v_ct[3] = 64'h3FA40E8A984D4815;
    v_key[4] = 64'h0E329232EA6D0D73; v_pt[4] = 64'h8787878787878787; v_ct[4] = 64'h0000000000000000;
    v_key[5] = 64'h1111111111111111; v_pt[5] = 64'h1111111111111111; v_ct[5] = 64'hF40379AB9E0EC533;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data_out", data_out, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Encrypt all reference vectors
    for (int i = 0; i < NV; i++) begin
      send(v_pt[i], v_key[i], v_ct[i], 1'b0);
      check_eq("busy_in_round", 64'(busy), 64'd1);
      check_eq("in_ready_in_round", 64'(in_ready), 64'd0);
      wait_drain();
    end

`ifdef DES_DECRYPT_EN
    // Decrypt the same vectors back to plaintext
    mode = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(v_ct[i], v_key[i], v_pt[i], 1'b0);
      wait_drain();
    end
    mode = 1'b0;
`endif

    // Output stall: result held, no new accept, in_ready returns the cycle after handshake
    out_ready = 1'b0;
    send(v_pt[0], v_key[0], v_ct[0], 1'b0);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("stall_data", data_out, v_ct[0]);
      check_eq("stall_valid", 64'(out_valid), 64'd1);
      check_eq("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("post_hs_valid", 64'(out_valid), 64'd0);
    check_eq("post_hs_in_ready", 64'(in_ready), 64'd1);
    check_eq("post_hs_busy", 64'(busy), 64'd0);
    wait_drain();

    // in_valid held with changing data during the rounds is ignored
    scramble = 1'b1;
    send(v_pt[3], v_key[3], v_ct[3], 1'b1);
    repeat (12) @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble = 1'b0;
    wait_drain();

    // Reset in the middle of a block discards it
    send(v_pt[1], v_key[1], v_ct[1], 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    check_eq("abort_out_valid", 64'(out_valid), 64'd0);
    check_eq("abort_data_out", data_out, 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_in_ready", 64'(in_ready), 64'd1);
    send(v_pt[0], v_key[0], v_ct[0], 1'b0);
    wait_drain();

    // Back-to-back: in_valid kept high, one result every 18 cycles
    prev_acc = 0;
    for (int i = 0; i < NV; i++) begin
      send(v_pt[i], v_key[i], v_ct[i], (i < NV - 1));
      if (i > 0) check_eq("b2b_interval", 64'(last_acc - prev_acc), 64'd18);
      prev_acc = last_acc;
    end
    wait_drain();

    // Random vector order with random downstream back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idx = $urandom_range(0, NV - 1);
      send(v_pt[idx], v_key[idx], v_ct[idx], 1'b0);
    end
    wait_drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
